dtc_walk: RTL



---
 rtl/dtc_walk_pkg.sv | 30 +++
 rtl/dtc_walk_if.sv | 35 +++
 rtl/dtc_node_ram.sv | 28 ++
 rtl/dtc_walk.sv | 105 ++++++++++
 4 files changed

// File: rtl/dtc_walk_pkg.sv
// dtc_walk_pkg: walker state type, width helpers and node-word field extraction
package dtc_walk_pkg;
  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;
  localparam int WORD_MAX = 64;
  typedef logic [WORD_MAX-1:0] word_t;
  function automatic int calc_fw(input int in_w);
    return in_w > 1 ? $clog2(in_w) : 1;
  endfunction
  function automatic int calc_nw(input int in_w, input int out_w, input int node_aw);
    return 1 + (calc_fw(in_w) + 2 * node_aw > out_w ? calc_fw(in_w) + 2 * node_aw : out_w);
  endfunction
  function automatic word_t field(input word_t w, input int lsb, input int width);
    return (w >> lsb) & ((word_t'(1) << width) - word_t'(1));
  endfunction
  function automatic logic node_is_leaf(input word_t w, input int nw);
    return field(w, nw - 1, 1) != '0;
  endfunction
  function automatic word_t node_feat(input word_t w, input int fw, input int aw);
    return field(w, 2 * aw, fw);
  endfunction
  function automatic word_t node_hi(input word_t w, input int aw);
    return field(w, aw, aw);
  endfunction
  function automatic word_t node_lo(input word_t w, input int aw);
    return field(w, 0, aw);
  endfunction
  function automatic word_t node_value(input word_t w, input int out_w);
    return field(w, 0, out_w);
  endfunction
endpackage

// File: rtl/dtc_walk_if.sv
// dtc_walk_if: walker handshake bundle; cfg_* signals exist only with DTC_WALK_PROG_EN
interface dtc_walk_if #(
  parameter int IN_W = 8,
  parameter int OUT_W = 8,
  parameter int NODE_AW = 5
) ();
  logic in_valid;
  logic in_ready;
  logic [IN_W-1:0] inp;
  logic out_valid;
  logic out_ready;
  logic [OUT_W-1:0] outp;
  logic out_err;
`ifdef DTC_WALK_PROG_EN
  import dtc_walk_pkg::*;
  localparam int NW = calc_nw(IN_W, OUT_W, NODE_AW);
  logic cfg_we;
  logic [NODE_AW-1:0] cfg_addr;
  logic [NW-1:0] cfg_data;
`endif
  modport master (
`ifdef DTC_WALK_PROG_EN
    output cfg_we, cfg_addr, cfg_data,
`endif
    output in_valid, inp, out_ready,
    input in_ready, out_valid, outp, out_err
  );
  modport slave (
`ifdef DTC_WALK_PROG_EN
    input cfg_we, cfg_addr, cfg_data,
`endif
    input in_valid, inp, out_ready,
    output in_ready, out_valid, outp, out_err
  );
endinterface

// File: rtl/dtc_node_ram.sv
// dtc_node_ram: 2**AW x NW synchronous-read node table; write port only with DTC_WALK_PROG_EN
module dtc_node_ram #(
  parameter int AW = 5,
  parameter int NW = 14
`ifndef DTC_WALK_PROG_EN
  , parameter logic [(2**AW)*NW-1:0] INIT = '0
`endif
) (
  input logic clk,
`ifdef DTC_WALK_PROG_EN
  input logic we,
  input logic [AW-1:0] waddr,
  input logic [NW-1:0] wdata,
`endif
  input logic [AW-1:0] raddr,
  output logic [NW-1:0] rdata
);
  logic [NW-1:0] mem [2**AW];
`ifdef DTC_WALK_PROG_EN
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
`else
  initial for (int i = 0; i < 2**AW; i++) mem[i] = INIT[i*NW +: NW];
  always_ff @(posedge clk) rdata <= mem[raddr];
`endif
endmodule

// File: rtl/dtc_walk.sv
// dtc_walk: decision-tree walker, one node per clock; DTC_WALK_PROG_EN adds run-time table writes
module dtc_walk
  import dtc_walk_pkg::*;
#(
  parameter int IN_W = 8,
  parameter int OUT_W = 8,
  parameter int NODE_AW = 5,
  parameter int MAX_DEPTH = 8
`ifndef DTC_WALK_PROG_EN
  , parameter logic [(2**NODE_AW)*calc_nw(IN_W, OUT_W, NODE_AW)-1:0] INIT = '0
`endif
) (
  input logic clk,
  input logic rst,
  dtc_walk_if.slave bus
);
  localparam int FW = calc_fw(IN_W);
  localparam int NW = calc_nw(IN_W, OUT_W, NODE_AW);
  localparam int CW = $clog2(MAX_DEPTH) + 1;
  state_t state, state_n;
  logic [IN_W-1:0] inp_q, inp_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [OUT_W-1:0] outp_n;
  logic valid_n, err_n, go_hi, leaf;
  logic [NW-1:0] word;
  logic [NODE_AW-1:0] raddr, hi, lo;
  logic [FW-1:0] feat;
  word_t w;
  assign w = word_t'(word);
  assign leaf = node_is_leaf(w, NW);
  assign feat = FW'(node_feat(w, FW, NODE_AW));
  assign hi = NODE_AW'(node_hi(w, NODE_AW));
  assign lo = NODE_AW'(node_lo(w, NODE_AW));
  assign go_hi = 32'(feat) < IN_W && inp_q[feat];
`ifdef DTC_WALK_PROG_EN
  logic wr;
  assign wr = bus.cfg_we && state == IDLE;
  assign bus.in_ready = state == IDLE && !bus.cfg_we;
`else
  assign bus.in_ready = state == IDLE;
`endif
  dtc_node_ram #(
    .AW(NODE_AW),
    .NW(NW)
`ifndef DTC_WALK_PROG_EN
    , .INIT(INIT)
`endif
  ) u_ram (
    .clk(clk),
`ifdef DTC_WALK_PROG_EN
    .we(wr),
    .waddr(bus.cfg_addr),
    .wdata(bus.cfg_data),
`endif
    .raddr(raddr),
    .rdata(word)
  );
  always_comb begin
    state_n = state;
    inp_n = inp_q;
    cnt_n = cnt;
    valid_n = bus.out_valid;
    outp_n = bus.outp;
    err_n = bus.out_err;
    raddr = '0;
    case (state)
      IDLE: if (bus.in_valid && bus.in_ready) begin
        state_n = WALK;
        inp_n = bus.inp;
        cnt_n = '0;
      end
      WALK: begin
        raddr = go_hi ? hi : lo;
        if (leaf || cnt == CW'(MAX_DEPTH - 1)) begin
          state_n = DONE;
          valid_n = 1'b1;
          outp_n = leaf ? OUT_W'(node_value(w, OUT_W)) : '0;
          err_n = !leaf;
        end else cnt_n = cnt + 1'b1;
      end
      DONE: if (bus.out_ready) begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      inp_q <= '0;
      cnt <= '0;
      bus.out_valid <= 1'b0;
      bus.outp <= '0;
      bus.out_err <= 1'b0;
    end else begin
      state <= state_n;
      inp_q <= inp_n;
      cnt <= cnt_n;
      bus.out_valid <= valid_n;
      bus.outp <= outp_n;
      bus.out_err <= err_n;
    end
  end
endmodule
